// File: rtl/proc_defs.sv
// Shared definitions for the processor core: jump condition codes and
// jump-unit state encodings, also used by the control-unit decoder.
package proc_defs;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    JU_RUN     = 2'd0,
    JU_OPERAND = 2'd1,
    JU_FLUSH   = 2'd2
  } ju_state_e;

  // True when a jump with condition code c must be taken given zero flag z.
  function automatic logic cond_met(input logic [1:0] c, input logic z);
    logic r;
    r = 1'b0;
    case (c)
      COND_ALWAYS: r = 1'b1;
      COND_Z:      r = z;
      COND_NZ:     r = ~z;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load has priority over increment, and the
// count wraps modulo 2^WIDTH.
module pc_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadVal;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/jump_unit.sv
// Conditional-jump resolver and PC owner. A jump request latches the
// condition and Z, steps the PC onto the operand word, waits for the
// operand, then either loads the target (taken pulse, then a flush
// cycle) or skips the operand word.
//
// Handshake: while busy=1 the decoder must hold off; jmpReq and incEn are
// ignored. In OPERAND, the operand is consumed in the first cycle where
// operandValid=1; there is no backpressure on the memory side.
module jump_unit
  import proc_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             zFlag,
  input  logic             incEn,
  input  logic             jmpReq,
  input  logic [1:0]       cond,
  input  logic [WIDTH-1:0] operand,
  input  logic             operandValid,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             taken,
  output logic             flush,
  output ju_state_e        dbgState
);

  ju_state_e        r_state;
  ju_state_e        w_next;
  logic [1:0]       r_cond;
  logic             r_z;
  logic             r_taken;
  logic             w_take;
  logic             w_load;
  logic             w_inc;

  // Condition evaluated only from values latched in the request cycle.
  assign w_take = cond_met(r_cond, r_z);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state <= JU_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. FLUSH lasts two cycles: the taken cycle, then the
  // flush cycle, so taken and flush are distinct pulses.
  always_comb begin
    w_next = r_state;
    case (r_state)
      JU_RUN:     if (jmpReq) w_next = JU_OPERAND;
      JU_OPERAND: if (operandValid) w_next = w_take ? JU_FLUSH : JU_RUN;
      JU_FLUSH:   w_next = r_taken ? JU_FLUSH : JU_RUN;
      default:    w_next = JU_RUN;
    endcase
  end

  // Output / PC-control logic; outputs depend only on registers.
  always_comb begin
    w_load = 1'b0;
    w_inc  = 1'b0;
    busy   = (r_state != JU_RUN);
    flush  = (r_state == JU_FLUSH) && !r_taken;
    case (r_state)
      JU_RUN:     w_inc = jmpReq | incEn;
      JU_OPERAND: begin
        if (operandValid) begin
          w_load = w_take;
          w_inc  = ~w_take;
        end
      end
      default: ;
    endcase
  end

  // Latch condition and Z in the request cycle.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_cond <= COND_ALWAYS;
      r_z    <= 1'b0;
    end else if (r_state == JU_RUN && jmpReq) begin
      r_cond <= cond;
      r_z    <= zFlag;
    end
  end

  // One-cycle taken pulse in the cycle after the operand is accepted.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_taken <= 1'b0;
    end else begin
      r_taken <= (r_state == JU_OPERAND) && operandValid && w_take;
    end
  end

  pc_counter #(.WIDTH(WIDTH)) u_pc (
    .clk     (clk),
    .rstN    (rstN),
    .load    (w_load),
    .loadVal (operand),
    .inc     (w_inc),
    .count   (pc)
  );

  assign taken    = r_taken;
  assign dbgState = r_state;

endmodule
